// File: rtl/aes_spi_slave_p.sv
// aes_spi_slave_p -- SPI mode-0 slave front-end for the AES core.
//
// Each chip-select frame carries a header byte (bit7 = mode, bits6:5 = key
// size), one BLOCK_W-bit data block and a 128/192/256-bit key. After the key
// the block launches the AES core (core_start/core_done handshake), then
// shifts the result back out on miso while cs_n is still low.
//
// Optional build macro: AES_SPI_LSB_FIRST_EN -- when defined, header, block,
// key and result transfer LSB-first (first-generation host compatibility).
// Default (undefined) is MSB-first.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   sclk, cs_n, mosi       asynchronous SPI inputs (synchronised here)
//   miso                   serial result, 0 outside the TX phase
//   core_start             one-cycle launch pulse to the AES core
//   core_mode, core_size   header fields, held until the next header
//   core_block, core_key   assembled block and right-justified key
//   core_done, core_result core completion pulse and its output
//   busy                   high whenever the FSM is not idle
//   frame_err              sticky framing error, cleared by next cs_n fall
module aes_spi_slave_p #(
    parameter int BLOCK_W     = 128,
    parameter int KEY_W_MAX   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [1:0]           core_size,
    output logic [BLOCK_W-1:0]   core_block,
    output logic [KEY_W_MAX-1:0] core_key,
    input  logic                 core_done,
    input  logic [BLOCK_W-1:0]   core_result,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int CNT_MAX = (BLOCK_W > KEY_W_MAX) ? BLOCK_W : KEY_W_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, HDR, DATA, KEY, START, WAIT, TX, DONE, ABORT
    } state_t;

    function automatic logic [CNT_W-1:0] key_len_f(input logic [1:0] size);
        case (size)
            2'b00:   key_len_f = CNT_W'(128);
            2'b01:   key_len_f = CNT_W'(192);
            default: key_len_f = CNT_W'(256);
        endcase
    endfunction

`ifdef AES_SPI_LSB_FIRST_EN
    function automatic logic [BLOCK_W-1:0] block_shift_f(input logic [BLOCK_W-1:0] v, input logic b);
        block_shift_f = {b, v[BLOCK_W-1:1]};
    endfunction
    // New bits enter at the top of the active key window so the key stays
    // right-justified once all key_len bits have arrived.
    function automatic logic [KEY_W_MAX-1:0] key_shift_f(input logic [KEY_W_MAX-1:0] v, input logic b,
                                                         input logic [CNT_W-1:0] len);
        key_shift_f = (v >> 1) | ({{(KEY_W_MAX-1){1'b0}}, b} << (len - CNT_W'(1)));
    endfunction
    function automatic logic [BLOCK_W-1:0] tx_shift_f(input logic [BLOCK_W-1:0] v);
        tx_shift_f = {1'b0, v[BLOCK_W-1:1]};
    endfunction
    function automatic logic tx_bit_f(input logic [BLOCK_W-1:0] v);
        tx_bit_f = v[0];
    endfunction
`else
    function automatic logic [BLOCK_W-1:0] block_shift_f(input logic [BLOCK_W-1:0] v, input logic b);
        block_shift_f = {v[BLOCK_W-2:0], b};
    endfunction
    // The key register is cleared when the header completes, so shifting
    // left leaves zeros above the active key length.
    function automatic logic [KEY_W_MAX-1:0] key_shift_f(input logic [KEY_W_MAX-1:0] v, input logic b,
                                                         input logic [CNT_W-1:0] len);
        key_shift_f = (len != '0) ? {v[KEY_W_MAX-2:0], b} : v;
    endfunction
    function automatic logic [BLOCK_W-1:0] tx_shift_f(input logic [BLOCK_W-1:0] v);
        tx_shift_f = {v[BLOCK_W-2:0], 1'b0};
    endfunction
    function automatic logic tx_bit_f(input logic [BLOCK_W-1:0] v);
        tx_bit_f = v[BLOCK_W-1];
    endfunction
`endif

    // Synchronisers: sampling flops only, left free-running through reset so
    // a cs_n held low across reset does not look like a new falling edge.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [6:0]             hdr_q, hdr_d;
    logic [7:0]             hdr_byte;
    logic [BLOCK_W-1:0]     tx_q, tx_d;
    logic [BLOCK_W-1:0]     core_block_q, core_block_d;
    logic [KEY_W_MAX-1:0]   core_key_q, core_key_d;
    logic                   core_mode_q, core_mode_d;
    logic [1:0]             core_size_q, core_size_d;
    logic                   core_start_q, core_start_d;
    logic                   frame_err_q, frame_err_d;
    logic                   miso_q, miso_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       key_len;

    assign key_len = key_len_f(core_size_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        tx_d         = tx_q;
        core_block_d = core_block_q;
        core_key_d   = core_key_q;
        core_mode_d  = core_mode_q;
        core_size_d  = core_size_q;
        core_start_d = 1'b0;
        frame_err_d  = frame_err_q;
`ifdef AES_SPI_LSB_FIRST_EN
        hdr_byte = {mosi_s, hdr_q};
`else
        hdr_byte = {hdr_q, mosi_s};
`endif
        // A cs_n rise before DONE aborts the frame; it outranks any sclk
        // edge or core_done seen in the same cycle.
        if (cs_rise && (state_q inside {HDR, DATA, KEY, START, WAIT, TX})) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d     = HDR;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                end
                HDR: if (sclk_rise) begin
`ifdef AES_SPI_LSB_FIRST_EN
                    hdr_d = hdr_byte[7:1];
`else
                    hdr_d = hdr_byte[6:0];
`endif
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (hdr_byte[6:5] == 2'b11) begin
                            state_d     = ABORT;
                            frame_err_d = 1'b1;
                        end else begin
                            state_d     = DATA;
                            core_mode_d = hdr_byte[7];
                            core_size_d = hdr_byte[6:5];
                            core_key_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: if (sclk_rise) begin
                    core_block_d = block_shift_f(core_block_q, mosi_s);
                    if (cnt_q == CNT_W'(BLOCK_W - 1)) begin
                        cnt_d   = '0;
                        state_d = KEY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                KEY: if (sclk_rise) begin
                    core_key_d = key_shift_f(core_key_q, mosi_s, key_len);
                    if (cnt_q == key_len - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                START: begin
                    core_start_d = 1'b1;
                    state_d      = WAIT;
                end
                WAIT: if (core_done) begin
                    tx_d    = core_result;
                    state_d = TX;
                end
                TX: if (sclk_fall) begin
                    tx_d = tx_shift_f(tx_q);
                    if (cnt_q == CNT_W'(BLOCK_W - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE, ABORT: if (cs_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // miso follows the shift register only while staying in TX, which
        // gives the result MSB one cycle after TX entry and 0 on exit.
        miso_d = (state_q == TX && state_d == TX) ? tx_bit_f(tx_d) : 1'b0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hdr_q        <= '0;
            tx_q         <= '0;
            core_block_q <= '0;
            core_key_q   <= '0;
            core_mode_q  <= 1'b0;
            core_size_q  <= 2'b00;
            core_start_q <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hdr_q        <= hdr_d;
            tx_q         <= tx_d;
            core_block_q <= core_block_d;
            core_key_q   <= core_key_d;
            core_mode_q  <= core_mode_d;
            core_size_q  <= core_size_d;
            core_start_q <= core_start_d;
            frame_err_q  <= frame_err_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
        end
    end

    assign miso       = miso_q;
    assign core_start = core_start_q;
    assign core_mode  = core_mode_q;
    assign core_size  = core_size_q;
    assign core_block = core_block_q;
    assign core_key   = core_key_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_aes_spi_slave_p.sv
// Directed testbench for aes_spi_slave_p (default MSB-first build).
module tb_aes_spi_slave_p;

    logic         clk = 1'b0;
    logic         reset, sclk, cs_n, mosi, core_done;
    logic         miso, core_start, core_mode, busy, frame_err;
    logic [1:0]   core_size;
    logic [127:0] core_block, core_result;
    logic [255:0] core_key;

    int checks = 0;
    int passes = 0;
    int start_cnt = 0;

    aes_spi_slave_p #(.BLOCK_W(128), .KEY_W_MAX(256), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .core_start(core_start), .core_mode(core_mode),
        .core_size(core_size), .core_block(core_block), .core_key(core_key),
        .core_done(core_done), .core_result(core_result),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b; tick(4); sclk = 1'b1; tick(8); sclk = 1'b0; tick(4);
    endtask

    task automatic send_bits(input logic [255:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic recv_bits(input int n, output logic [127:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = {r[126:0], miso};
            sclk = 1'b1; tick(8); sclk = 1'b0; tick(8);
        end
    endtask

    task automatic load_frame(input logic [7:0] hdr, input logic [127:0] blk,
                              input logic [255:0] key, input int nkey);
        cs_n = 1'b0; tick(6);
        send_bits({248'h0, hdr}, 8);
        send_bits({128'h0, blk}, 128);
        send_bits(key, nkey);
    endtask

    // Core model: answers roughly 20 cycles after the start pulse.
    task automatic core_reply(input logic [127:0] res);
        tick(12);
        core_result = res; core_done = 1'b1; tick(1); core_done = 1'b0;
        tick(2);
    endtask

    localparam logic [127:0] BLK1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY1 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [127:0] RES1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY3 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [127:0] RES3 = 128'hfedcba98765432100123456789abcdef;

    initial begin
        logic [127:0] rx;
        int           s0, lat;

        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        core_done = 1'b0; core_result = '0;
        tick(5); reset = 1'b0; tick(2);

        chk("rst_miso", {255'h0, miso}, 256'h0);
        chk("rst_start", {255'h0, core_start}, 256'h0);
        chk("rst_mode", {255'h0, core_mode}, 256'h0);
        chk("rst_size", {254'h0, core_size}, 256'h0);
        chk("rst_block", {128'h0, core_block}, 256'h0);
        chk("rst_key", core_key, 256'h0);
        chk("rst_busy", {255'h0, busy}, 256'h0);
        chk("rst_err", {255'h0, frame_err}, 256'h0);

        // Encrypt, 128-bit key
        s0 = start_cnt;
        load_frame(8'h00, BLK1, KEY1, 128);
        chk("enc_start_once", start_cnt - s0, 1);
        chk("enc_mode", {255'h0, core_mode}, 256'h0);
        chk("enc_size", {254'h0, core_size}, 256'h0);
        chk("enc_block", {128'h0, core_block}, {128'h0, BLK1});
        chk("enc_key", core_key, KEY1);
        chk("enc_busy_wait", {255'h0, busy}, 256'h1);
        core_reply(RES1);
        recv_bits(128, rx);
        chk("enc_result", {128'h0, rx}, {128'h0, RES1});
        chk("enc_done_miso", {255'h0, miso}, 256'h0);
        chk("enc_err", {255'h0, frame_err}, 256'h0);
        chk("enc_start_total", start_cnt - s0, 1);
        cs_n = 1'b1; tick(6);
        chk("enc_idle_busy", {255'h0, busy}, 256'h0);

        // Decrypt, 256-bit key
        s0 = start_cnt;
        load_frame(8'hC0, BLK2, KEY2, 256);
        chk("dec_start_once", start_cnt - s0, 1);
        chk("dec_mode", {255'h0, core_mode}, 256'h1);
        chk("dec_size", {254'h0, core_size}, 256'h2);
        chk("dec_key", core_key, KEY2);
        core_reply(BLK1);
        recv_bits(128, rx);
        chk("dec_result", {128'h0, rx}, {128'h0, BLK1});
        cs_n = 1'b1; tick(6);
        chk("dec_err", {255'h0, frame_err}, 256'h0);

        // 192-bit key: start fires only after the 328th rising sclk edge
        s0 = start_cnt;
        cs_n = 1'b0; tick(6);
        send_bits({248'h0, 8'h20}, 8);
        send_bits({128'h0, BLK2}, 128);
        send_bits(KEY3 >> 1, 191);
        chk("k192_no_early_start", start_cnt - s0, 0);
        mosi = KEY3[0]; tick(4); sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (core_start === 1'b1 && lat == 0) lat = k;
        end
        sclk = 1'b0; tick(4);
        chk("k192_start_latency", lat, 4);
        chk("k192_start_once", start_cnt - s0, 1);
        chk("k192_size", {254'h0, core_size}, 256'h1);
        chk("k192_key_hi_zero", {192'h0, core_key[255:192]}, 256'h0);
        chk("k192_key", core_key, KEY3);
        core_reply(RES3);
        recv_bits(128, rx);
        chk("k192_result", {128'h0, rx}, {128'h0, RES3});
        cs_n = 1'b1; tick(6);

        // Reserved size
        s0 = start_cnt;
        cs_n = 1'b0; tick(6);
        send_bits({248'h0, 8'h60}, 8);
        tick(4);
        chk("rsv_err", {255'h0, frame_err}, 256'h1);
        chk("rsv_miso", {255'h0, miso}, 256'h0);
        chk("rsv_busy_abort", {255'h0, busy}, 256'h1);
        send_bits(256'hff, 8);
        chk("rsv_no_start", start_cnt - s0, 0);
        chk("rsv_miso_clk", {255'h0, miso}, 256'h0);
        cs_n = 1'b1; tick(6);
        chk("rsv_idle", {255'h0, busy}, 256'h0);
        chk("rsv_err_sticky", {255'h0, frame_err}, 256'h1);
        cs_n = 1'b0; tick(6);
        chk("rsv_err_cleared", {255'h0, frame_err}, 256'h0);
        cs_n = 1'b1; tick(6);

        // Abort after 50 data bits
        s0 = start_cnt;
        cs_n = 1'b0; tick(6);
        send_bits(256'h0, 8);
        send_bits({128'h0, BLK1} >> 78, 50);
        cs_n = 1'b1; tick(6);
        chk("abt_err", {255'h0, frame_err}, 256'h1);
        chk("abt_idle", {255'h0, busy}, 256'h0);
        chk("abt_block_kept", {206'h0, core_block[49:0]}, {206'h0, BLK1[127:78]});
        core_result = RES1; core_done = 1'b1; tick(1); core_done = 1'b0;
        tick(4);
        chk("abt_done_miso", {255'h0, miso}, 256'h0);
        chk("abt_done_busy", {255'h0, busy}, 256'h0);
        chk("abt_no_start", start_cnt - s0, 0);

        // Reset in TX after 40 result bits, then a clean frame
        load_frame(8'h00, BLK1, KEY1, 128);
        core_reply(RES1);
        recv_bits(40, rx);
        chk("rtx_partial", {216'h0, rx[39:0]}, {216'h0, RES1[127:88]});
        reset = 1'b1; tick(1);
        chk("rtx_miso", {255'h0, miso}, 256'h0);
        chk("rtx_busy", {255'h0, busy}, 256'h0);
        reset = 1'b0;
        cs_n = 1'b1; tick(6);
        chk("rtx_err", {255'h0, frame_err}, 256'h0);
        s0 = start_cnt;
        load_frame(8'h00, BLK1, KEY1, 128);
        chk("rtx2_start", start_cnt - s0, 1);
        core_reply(RES1);
        recv_bits(128, rx);
        chk("rtx2_result", {128'h0, rx}, {128'h0, RES1});
        cs_n = 1'b1; tick(6);
        chk("rtx2_err", {255'h0, frame_err}, 256'h0);
        chk("rtx2_idle", {255'h0, busy}, 256'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
